// File: rtl/osd_ring_router_pkg.sv
// Shared types and constants for the multi-port DII ring router.
package osd_ring_router_pkg;

  localparam int unsigned DII_FLIT_W = 16;
  localparam int unsigned DEST_LSB   = 0;
  localparam int unsigned DEST_MSB   = 15;
  localparam int unsigned STAT_W     = 16;

  typedef enum logic [1:0] {
    RS_IDLE,
    RS_LOCAL,
    RS_FWD,
    RS_DROP
  } route_state_t;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/osd_ring_router_multi_fifo.sv
// Ring-ingress flit buffer: synchronous FIFO with full/empty flags and a combinational head.
module dii_buf_fifo #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_en,
  output logic [WIDTH-1:0] rd_data,
  input  logic             rd_en,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/osd_ring_router_multi.sv
// Buffered debug-ring stop serving NUM_LOCAL modules at IDs BASE_ID..BASE_ID+NUM_LOCAL-1.
// Optional statistics counters enabled by defining OSD_RING_ROUTER_STATS_EN.
module osd_ring_router_multi
  import osd_ring_router_pkg::*;
#(
  parameter logic [15:0] BASE_ID   = 16'h0001,
  parameter int unsigned NUM_LOCAL = 3,
  parameter int unsigned BUF_DEPTH = 4,
  parameter int unsigned RING_PRIO = 0
) (
  input  logic                            clk,
  input  logic                            rst,
`ifdef OSD_RING_ROUTER_STATS_EN
  output logic [STAT_W-1:0]               stat_fwd,
  output logic [STAT_W-1:0]               stat_local,
  output logic [STAT_W-1:0]               stat_drop,
`endif
  input  logic [DII_FLIT_W-1:0]           ring_in_data,
  input  logic                            ring_in_first,
  input  logic                            ring_in_last,
  input  logic                            ring_in_valid,
  output logic                            ring_in_ready,
  output logic [DII_FLIT_W-1:0]           ring_out_data,
  output logic                            ring_out_first,
  output logic                            ring_out_last,
  output logic                            ring_out_valid,
  input  logic                            ring_out_ready,
  input  logic [NUM_LOCAL*DII_FLIT_W-1:0] local_in_data,
  input  logic [NUM_LOCAL-1:0]            local_in_first,
  input  logic [NUM_LOCAL-1:0]            local_in_last,
  input  logic [NUM_LOCAL-1:0]            local_in_valid,
  output logic [NUM_LOCAL-1:0]            local_in_ready,
  output logic [NUM_LOCAL*DII_FLIT_W-1:0] local_out_data,
  output logic [NUM_LOCAL-1:0]            local_out_first,
  output logic [NUM_LOCAL-1:0]            local_out_last,
  output logic [NUM_LOCAL-1:0]            local_out_valid,
  input  logic [NUM_LOCAL-1:0]            local_out_ready
);

  localparam int unsigned NS    = NUM_LOCAL + 1;
  localparam int unsigned SRC_W = $clog2(NS);
  localparam int unsigned IDX_W = (NUM_LOCAL > 1) ? $clog2(NUM_LOCAL) : 1;
  localparam int unsigned FW    = DII_FLIT_W + 2;
  localparam int unsigned OW    = DII_FLIT_W + 1;

  logic [FW-1:0]         head;
  logic                  fifo_full, fifo_empty, fifo_pop;
  logic                  head_first, head_last;
  logic [DII_FLIT_W-1:0] head_data;
  logic [DII_FLIT_W-1:0] head_dest;
  logic [OW-1:0]         dest_off;
  logic                  dest_local;

  route_state_t          state_q, state_d, eff_state;
  logic [IDX_W-1:0]      idx_q, idx_d, eff_idx;
  logic                  lo_valid, local_fire, fwd_valid, fwd_fire;

  logic [NS-1:0]         src_valid, src_first, src_last, req;
  logic [DII_FLIT_W-1:0] src_data [NS];
  logic [SRC_W-1:0]      ptr_q, grant_q, pick, cur;
  logic                  lock_q, found, have_grant, ring_fire;

  dii_buf_fifo #(
    .WIDTH (FW),
    .DEPTH (BUF_DEPTH)
  ) u_ingress_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_data ({ring_in_first, ring_in_last, ring_in_data}),
    .wr_en   (ring_in_valid),
    .rd_data (head),
    .rd_en   (fifo_pop),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign ring_in_ready = !fifo_full;
  assign head_first    = head[FW-1];
  assign head_last     = head[FW-2];
  assign head_data     = head[DII_FLIT_W-1:0];
  assign head_dest     = head_data[DEST_MSB:DEST_LSB];
  assign dest_off      = {1'b0, head_dest} - {1'b0, BASE_ID};
  assign dest_local    = ({1'b0, head_dest} >= {1'b0, BASE_ID}) && (dest_off < OW'(NUM_LOCAL));

  // IDLE resolves the route from the head combinationally so the first flit leaves in the same cycle.
  always_comb begin
    eff_state = state_q;
    eff_idx   = idx_q;
    if (state_q == RS_IDLE && !fifo_empty) begin
      if (!head_first) begin
        eff_state = RS_DROP;
      end else if (dest_local) begin
        eff_state = RS_LOCAL;
        eff_idx   = IDX_W'(dest_off);
      end else begin
        eff_state = RS_FWD;
      end
    end
    lo_valid        = !rst && !fifo_empty && (eff_state == RS_LOCAL);
    local_out_valid = '0;
    if (lo_valid) local_out_valid[eff_idx] = 1'b1;
    local_fire = lo_valid && local_out_ready[eff_idx];
    fwd_valid  = !rst && !fifo_empty && (eff_state == RS_FWD);
    case (eff_state)
      RS_LOCAL: fifo_pop = local_fire;
      RS_FWD:   fifo_pop = fwd_fire;
      RS_DROP:  fifo_pop = !fifo_empty;
      default:  fifo_pop = 1'b0;
    endcase
    state_d = eff_state;
    idx_d   = eff_idx;
    if (fifo_pop && head_last) state_d = RS_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RS_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign local_out_data  = {NUM_LOCAL{head_data}};
  assign local_out_first = {NUM_LOCAL{head_first}};
  assign local_out_last  = {NUM_LOCAL{head_last}};

  always_comb begin
    int unsigned j;
    src_valid[0] = fwd_valid;
    src_first[0] = head_first;
    src_last[0]  = head_last;
    src_data[0]  = head_data;
    for (int unsigned k = 0; k < NUM_LOCAL; k++) begin
      src_valid[k+1] = !rst && local_in_valid[k];
      src_first[k+1] = local_in_first[k];
      src_last[k+1]  = local_in_last[k];
      src_data[k+1]  = local_in_data[k*DII_FLIT_W +: DII_FLIT_W];
    end
    req   = src_valid & src_first;
    found = 1'b0;
    pick  = ptr_q;
    for (int unsigned i = 1; i <= NS; i++) begin
      j = (32'(ptr_q) + i) % NS;
      if (!found && req[j]) begin
        found = 1'b1;
        pick  = SRC_W'(j);
      end
    end
    if (RING_PRIO != 0 && req[0]) begin
      found = 1'b1;
      pick  = '0;
    end
    cur            = lock_q ? grant_q : pick;
    have_grant     = lock_q || found;
    ring_out_valid = have_grant && src_valid[cur];
    ring_out_data  = src_data[cur];
    ring_out_first = src_first[cur];
    ring_out_last  = src_last[cur];
    ring_fire      = ring_out_valid && ring_out_ready;
    fwd_fire       = ring_fire && (cur == '0);
    for (int unsigned k = 0; k < NUM_LOCAL; k++) begin
      local_in_ready[k] = !rst && have_grant && (cur == SRC_W'(k + 1)) && ring_out_ready;
    end
  end

  // The grant locks as soon as it is presented so ring_out stays stable while ring_out_ready is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q  <= 1'b0;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      if (!lock_q && found) ptr_q <= pick;
      if (ring_fire && src_last[cur]) begin
        lock_q <= 1'b0;
      end else if (have_grant) begin
        lock_q  <= 1'b1;
        grant_q <= cur;
      end
    end
  end

`ifdef OSD_RING_ROUTER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fwd   <= '0;
      stat_local <= '0;
      stat_drop  <= '0;
    end else begin
      if (fwd_fire && head_last) stat_fwd <= sat_inc(stat_fwd);
      if (local_fire && head_last) stat_local <= sat_inc(stat_local);
      if (eff_state == RS_DROP && fifo_pop) stat_drop <= sat_inc(stat_drop);
    end
  end
`endif

endmodule

// File: tb/tb_osd_ring_router_multi.sv
// Scoreboard bench for osd_ring_router_multi: directed scenarios followed by randomized traffic.
module tb_osd_ring_router_multi;

  localparam logic [15:0] BASE = 16'h0001;
  localparam int NL = 3;
  localparam int NS = NL + 1;

  logic clk = 1'b0;
  logic rst;
  logic [15:0] ring_in_data;
  logic ring_in_first, ring_in_last, ring_in_valid, ring_in_ready;
  logic [15:0] ring_out_data;
  logic ring_out_first, ring_out_last, ring_out_valid, ring_out_ready;
  logic [NL*16-1:0] local_in_data, local_out_data;
  logic [NL-1:0] local_in_first, local_in_last, local_in_valid, local_in_ready;
  logic [NL-1:0] local_out_first, local_out_last, local_out_valid, local_out_ready;
`ifdef OSD_RING_ROUTER_STATS_EN
  logic [15:0] stat_fwd, stat_local, stat_drop;
`endif

  logic rand_ready = 1'b0;
  logic man_ring_rdy;
  logic [NL-1:0] man_loc_rdy;
  logic rnd_ring_rdy = 1'b1;
  logic [NL-1:0] rnd_loc_rdy = '1;
  assign ring_out_ready  = rand_ready ? rnd_ring_rdy : man_ring_rdy;
  assign local_out_ready = rand_ready ? rnd_loc_rdy : man_loc_rdy;

  osd_ring_router_multi #(
    .BASE_ID   (BASE),
    .NUM_LOCAL (NL),
    .BUF_DEPTH (4),
    .RING_PRIO (0)
  ) dut (
    .clk             (clk),
    .rst             (rst),
`ifdef OSD_RING_ROUTER_STATS_EN
    .stat_fwd        (stat_fwd),
    .stat_local      (stat_local),
    .stat_drop       (stat_drop),
`endif
    .ring_in_data    (ring_in_data),
    .ring_in_first   (ring_in_first),
    .ring_in_last    (ring_in_last),
    .ring_in_valid   (ring_in_valid),
    .ring_in_ready   (ring_in_ready),
    .ring_out_data   (ring_out_data),
    .ring_out_first  (ring_out_first),
    .ring_out_last   (ring_out_last),
    .ring_out_valid  (ring_out_valid),
    .ring_out_ready  (ring_out_ready),
    .local_in_data   (local_in_data),
    .local_in_first  (local_in_first),
    .local_in_last   (local_in_last),
    .local_in_valid  (local_in_valid),
    .local_in_ready  (local_in_ready),
    .local_out_data  (local_out_data),
    .local_out_first (local_out_first),
    .local_out_last  (local_out_last),
    .local_out_valid (local_out_valid),
    .local_out_ready (local_out_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int ring_acc_cnt = 0;
  int ring_first_acc_cyc = 0;
  int ring_first_out_cyc = 0;
  int done_cnt = 0;

  // Model state: per-source queues of flits awaiting ring_out, per-port queues for local delivery.
  logic [17:0] exp_src [NS][$];
  logic [17:0] exp_loc [NL][$];
  logic [17:0] pkt [$];
  int served [$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc > 60000) begin
      $display("FAIL watchdog: cycle %0d exceeded, required completion before 60000", cyc);
      $fatal(1);
    end
  end

  always begin
    @(posedge clk);
    #1;
    rnd_ring_rdy = ($urandom_range(0, 3) != 0);
    for (int k = 0; k < NL; k++) rnd_loc_rdy[k] = ($urandom_range(0, 2) != 0);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  function automatic bit is_local(input logic [15:0] d);
    return (d >= BASE) && (d < BASE + NL);
  endfunction

  // Ring_out monitor: a packet must match, flit by flit, the head packet of at least one source.
  bit rin_pkt = 0;
  int rpos = 0;
  logic [NS-1:0] cand;
  always @(negedge clk) begin
    logic [17:0] got;
    if (rst) begin
      rin_pkt = 0;
    end else begin
      for (int k = 0; k < NL; k++) begin
        if (local_out_valid[k] && local_out_ready[k]) begin
          got = {local_out_first[k], local_out_last[k], local_out_data[k*16 +: 16]};
          if (exp_loc[k].size() == 0) chk($sformatf("local_out%0d_unexpected", k), 32'(got), 32'h3ffff);
          else chk($sformatf("local_out%0d_flit", k), 32'(got), 32'(exp_loc[k].pop_front()));
        end
      end
      if (ring_out_valid && ring_out_ready) begin
        got = {ring_out_first, ring_out_last, ring_out_data};
        if (!rin_pkt) begin
          rpos = 0;
          cand = '0;
          if (got[17]) ring_first_out_cyc = cyc;
          for (int s = 0; s < NS; s++)
            if (exp_src[s].size() > 0 && exp_src[s][0] == got) cand[s] = 1'b1;
        end else begin
          for (int s = 0; s < NS; s++)
            if (cand[s] && !(exp_src[s].size() > rpos && exp_src[s][rpos] == got)) cand[s] = 1'b0;
        end
        n_checks++;
        if (cand == '0) begin
          $display("FAIL ring_out_flit: got %h at packet offset %0d, expected a flit of a pending packet", got, rpos);
          rin_pkt = 0;
        end else begin
          n_pass++;
          if (got[16]) begin
            for (int s = 0; s < NS; s++) begin
              if (cand[s]) begin
                for (int i = 0; i <= rpos; i++) void'(exp_src[s].pop_front());
                served.push_back(s);
                break;
              end
            end
            rin_pkt = 0;
          end else begin
            rpos++;
            rin_pkt = 1;
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_ring_flit(input logic [17:0] f);
    bit ok = 0;
    int n = 0;
    ring_in_first = f[17];
    ring_in_last  = f[16];
    ring_in_data  = f[15:0];
    ring_in_valid = 1'b1;
    while (!ok && n < 400) begin
      @(negedge clk);
      ok = ring_in_ready;
      if (ok) begin
        ring_acc_cnt++;
        if (f[17]) ring_first_acc_cyc = cyc;
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL ring_in_handshake: flit %h not accepted, required within 400 cycles", f);
    end
  endtask

  task automatic send_local_flit(input int k, input logic [17:0] f);
    bit ok = 0;
    int n = 0;
    local_in_first[k] = f[17];
    local_in_last[k]  = f[16];
    local_in_data[k*16 +: 16] = f[15:0];
    local_in_valid[k] = 1'b1;
    while (!ok && n < 2000) begin
      @(negedge clk);
      ok = local_in_ready[k];
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL local_in%0d_handshake: flit %h not accepted, required within 2000 cycles", k, f);
    end
  endtask

  task automatic send_pkt();
    for (int i = 0; i < pkt.size(); i++) send_ring_flit(pkt[i]);
    ring_in_valid = 1'b0;
  endtask

  task automatic expect_loc(input int k);
    for (int i = 0; i < pkt.size(); i++) exp_loc[k].push_back(pkt[i]);
  endtask

  task automatic wait_drained(input int budget);
    int n = 0;
    bit empty_all = 0;
    while (!empty_all && n < budget) begin
      empty_all = 1;
      for (int s = 0; s < NS; s++) if (exp_src[s].size() != 0) empty_all = 0;
      for (int k = 0; k < NL; k++) if (exp_loc[k].size() != 0) empty_all = 0;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic ring_driver(input int npkt);
    logic [17:0] f [4];
    int len, tgt;
    logic [15:0] d;
    for (int p = 0; p < npkt; p++) begin
      int r = $urandom_range(0, 9);
      len = $urandom_range(1, 4);
      if (r == 0) begin
        tgt = -1;
        len = $urandom_range(1, 2);
        d = 16'($urandom);
      end else if (r < 5) begin
        d = BASE + 16'($urandom_range(0, NL - 1));
        tgt = int'(d - BASE);
      end else begin
        do d = 16'($urandom); while (is_local(d));
        tgt = NL;
      end
      for (int i = 0; i < len; i++)
        f[i] = {(r != 0) && (i == 0), i == len - 1, (i == 0) ? d : 16'($urandom)};
      for (int i = 0; i < len; i++) begin
        if (tgt == NL) exp_src[0].push_back(f[i]);
        else if (tgt >= 0) exp_loc[tgt].push_back(f[i]);
      end
      for (int i = 0; i < len; i++) send_ring_flit(f[i]);
      ring_in_valid = 1'b0;
      idle($urandom_range(0, 3));
    end
    done_cnt++;
  endtask

  task automatic local_driver(input int k, input int npkt);
    logic [17:0] f [4];
    int len;
    logic [15:0] d;
    for (int p = 0; p < npkt; p++) begin
      len = $urandom_range(1, 4);
      d = ($urandom_range(0, 1) == 0) ? BASE + 16'($urandom_range(0, NL - 1)) : 16'($urandom);
      for (int i = 0; i < len; i++) begin
        f[i] = {i == 0, i == len - 1, (i == 0) ? d : 16'($urandom)};
        exp_src[k + 1].push_back(f[i]);
      end
      for (int i = 0; i < len; i++) send_local_flit(k, f[i]);
      local_in_valid[k] = 1'b0;
      idle($urandom_range(0, 4));
    end
    done_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    ring_in_data = '0; ring_in_first = 0; ring_in_last = 0; ring_in_valid = 0;
    local_in_data = '0; local_in_first = '0; local_in_last = '0; local_in_valid = '0;
    man_ring_rdy = 1'b1;
    man_loc_rdy = '1;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ring_out_valid", 32'(ring_out_valid), 0);
    chk("reset_local_out_valid", 32'(local_out_valid), 0);
    chk("reset_local_in_ready", 32'(local_in_ready), 0);
    chk("reset_ring_in_ready", 32'(ring_in_ready), 1);
    idle(1);

    // Ring packet addressed to local port 1.
    pkt = '{{2'b10, 16'h0002}, {2'b00, 16'h0000}, {2'b01, 16'hAAAA}};
    expect_loc(1);
    send_pkt();
    idle(6);
    chk("local1_delivered", 32'(exp_loc[1].size()), 0);

    // Ring packet forwarded, one cycle ingress-to-egress.
    pkt = '{{2'b10, 16'h0007}, {2'b01, 16'hBEEF}};
    for (int i = 0; i < pkt.size(); i++) exp_src[0].push_back(pkt[i]);
    send_pkt();
    idle(6);
    chk("fwd_delivered", 32'(exp_src[0].size()), 0);
    chk("fwd_latency", 32'(ring_first_out_cyc - ring_first_acc_cyc), 1);
`ifdef OSD_RING_ROUTER_STATS_EN
    chk("stat_fwd", 32'(stat_fwd), 1);
    chk("stat_local", 32'(stat_local), 1);
`endif

    // Two local injectors start together; round-robin serves port 0 before port 2.
    served.delete();
    begin
      logic [17:0] a [3];
      logic [17:0] b [3];
      a = '{{2'b10, 16'h0010}, {2'b00, 16'h1111}, {2'b01, 16'h2222}};
      b = '{{2'b10, 16'h0020}, {2'b00, 16'h3333}, {2'b01, 16'h4444}};
      for (int i = 0; i < 3; i++) begin
        exp_src[1].push_back(a[i]);
        exp_src[3].push_back(b[i]);
      end
      fork
        begin
          for (int i = 0; i < 3; i++) send_local_flit(0, a[i]);
          local_in_valid[0] = 1'b0;
        end
        begin
          for (int i = 0; i < 3; i++) send_local_flit(2, b[i]);
          local_in_valid[2] = 1'b0;
        end
      join
    end
    idle(4);
    chk("rr_packets_served", 32'(served.size()), 2);
    if (served.size() == 2) begin
      chk("rr_first_source", 32'(served[0]), 1);
      chk("rr_second_source", 32'(served[1]), 3);
    end

    // Blocked local port fills the ingress FIFO.
    man_loc_rdy[0] = 1'b0;
    ring_acc_cnt = 0;
    pkt = '{{2'b10, 16'h0001}, {2'b00, 16'h5001}, {2'b00, 16'h5002}, {2'b00, 16'h5003}, {2'b01, 16'h5004}};
    expect_loc(0);
    done_cnt = 0;
    fork
      begin
        send_pkt();
        done_cnt++;
      end
    join_none
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("bp_accepted", 32'(ring_acc_cnt), 4);
    chk("bp_ring_in_ready", 32'(ring_in_ready), 0);
    @(posedge clk);
    #1;
    man_loc_rdy[0] = 1'b1;
    for (int n = 0; n < 200 && done_cnt == 0; n++) idle(1);
    idle(8);
    chk("bp_all_delivered", 32'(exp_loc[0].size()), 0);

    // Orphan flit dropped, then a normal packet to port 2.
    pkt = '{{2'b01, 16'h1234}};
    send_pkt();
    idle(3);
`ifdef OSD_RING_ROUTER_STATS_EN
    chk("stat_drop", 32'(stat_drop), 1);
`endif
    pkt = '{{2'b10, 16'h0003}, {2'b01, 16'h7777}};
    expect_loc(2);
    send_pkt();
    idle(6);
    chk("after_orphan_delivered", 32'(exp_loc[2].size()), 0);

    // Reset asserted with flit 2 of 4 of a stalled packet.
    man_loc_rdy[1] = 1'b0;
    send_ring_flit({2'b10, 16'h0002});
    ring_in_first = 1'b0;
    ring_in_last  = 1'b0;
    ring_in_data  = 16'hC0DE;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ring_in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_local_out_valid", 32'(local_out_valid), 0);
    chk("midrst_ring_out_valid", 32'(ring_out_valid), 0);
    chk("midrst_fifo_empty_ready", 32'(ring_in_ready), 1);
`ifdef OSD_RING_ROUTER_STATS_EN
    chk("midrst_stat_drop", 32'(stat_drop), 0);
`endif
    idle(1);
    man_loc_rdy[1] = 1'b1;
    pkt = '{{2'b10, 16'h0002}, {2'b01, 16'h9999}};
    expect_loc(1);
    send_pkt();
    idle(6);
    chk("postrst_delivered", 32'(exp_loc[1].size()), 0);

    // Randomized mixed traffic with random back-pressure.
    rand_ready = 1'b1;
    done_cnt = 0;
    fork
      ring_driver(40);
      local_driver(0, 12);
      local_driver(1, 12);
      local_driver(2, 12);
    join
    idle(2);
    rand_ready = 1'b0;
    wait_drained(1000);
    idle(4);
    for (int s = 0; s < NS; s++) chk($sformatf("drain_src%0d", s), 32'(exp_src[s].size()), 0);
    for (int k = 0; k < NL; k++) chk($sformatf("drain_local%0d", k), 32'(exp_loc[k].size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
